// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared state encoding and default width for the serial link
package serial_rx_pkg;

    // Default frame width, shared with the transmitter so both ends agree.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Raw state encodings, shared with the transmitter.
    localparam logic [1:0] STATE_IDLE     = 2'b00;
    localparam logic [1:0] STATE_SHIFT    = 2'b01;
    localparam logic [1:0] STATE_WAIT_LOW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = STATE_IDLE,
        S_SHIFT    = STATE_SHIFT,
        S_WAIT_LOW = STATE_WAIT_LOW
    } state_e;

endpackage

// File: rtl/serial_rx_sipo_register.sv
// rtl/serial_rx_sipo_register.sv - serial-in/parallel-out shift register, MSB first
module sipo_register
    import serial_rx_pkg::*;
#(
    parameter int Nbits = DEFAULT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             shift_enable,
    input  logic             serial_in,
    output logic [Nbits-1:0] out
);

    logic [Nbits-1:0] shift_q;
    logic [Nbits-1:0] shift_d;

    // Shift left, new bit at LSB, so the first bit received ends up at the MSB.
    always_comb begin
        shift_d = shift_q;
        if (shift_enable) begin
            shift_d = {shift_q[Nbits-2:0], serial_in};
        end
    end

    // Shift register storage with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out = shift_q;

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - serial frame receiver with valid/ack handshake and error flags
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  frame_en,
    input  logic                  read_ack,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  bit_count
);

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;

    logic                  shift_en;
    logic                  word_done;
    logic [DATA_WIDTH-2:0] head_bits;
    logic [DATA_WIDTH-1:0] word;

    // Bits are only accepted while a frame is being assembled; WAIT_LOW ignores extras.
    assign shift_en  = frame_en && (state_q != S_WAIT_LOW);
    assign word_done = (state_q == S_SHIFT) && frame_en && (cnt_q == LAST_BIT);

    // The register holds the first DATA_WIDTH-1 bits; the final bit is taken
    // straight from the line so the word is available one clock after its edge.
    sipo_register #(
        .Nbits (DATA_WIDTH - 1)
    ) u_sipo (
        .clk          (clk),
        .clr_n        (~rst),
        .shift_enable (shift_en),
        .serial_in    (serial_in),
        .out          (head_bits)
    );

    assign word = {head_bits, serial_in};

    // State, bit counter and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing: count bits, detect completion and early frame end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_en) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            S_SHIFT: begin
                if (frame_en) begin
                    if (cnt_q == LAST_BIT) begin
                        state_d = S_WAIT_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    // Truncated frame: drop it and flag for one cycle.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ferr_d  = 1'b1;
                end
            end
            S_WAIT_LOW: begin
                cnt_d = '0;
                if (!frame_en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output word holding register and handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // A completed word always loads; overrun only if the old word was still unread.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (word_done) begin
            data_d  = word;
            valid_d = 1'b1;
            if (read_ack) begin
                ovr_d = 1'b0;
            end else if (valid_q) begin
                ovr_d = 1'b1;
            end
        end else if (read_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);
    assign bit_count  = cnt_q;

endmodule
